// File: rtl/key_conditioner_if.sv
// Key pin bundle between the board KEY pins and the conditioner.
// Raw inputs are active-low; all conditioned outputs are active-high.
interface key_conditioner_if #(
  parameter int NUM_KEYS = 4
);
  logic [NUM_KEYS-1:0] key_n_raw;
  logic [NUM_KEYS-1:0] key_level;
  logic [NUM_KEYS-1:0] key_press;
  logic [NUM_KEYS-1:0] key_release;
  logic [NUM_KEYS-1:0] key_repeat;

  modport master (
    output key_n_raw,
    input  key_level,
    input  key_press,
    input  key_release,
    input  key_repeat
  );

  modport slave (
    input  key_n_raw,
    output key_level,
    output key_press,
    output key_release,
    output key_repeat
  );
endinterface

// File: rtl/key_conditioner.sv
// Per-key synchroniser, debouncer, edge pulses and auto-repeat.
// Channels are independent; counters never exceed their threshold.
module key_conditioner #(
  parameter int                  NUM_KEYS        = 4,
  parameter int                  CNT_W           = 24,
  parameter logic [CNT_W-1:0]    DEBOUNCE_CYCLES = 24'd500000,
  parameter logic [CNT_W-1:0]    REPEAT_DELAY    = 24'd12500000,
  parameter logic [CNT_W-1:0]    REPEAT_PERIOD   = 24'd5000000,
  parameter logic [NUM_KEYS-1:0] REPEAT_MASK     = 4'b0011
) (
  input logic              clk,
  input logic              rst,
  key_conditioner_if.slave kif
);

  typedef enum logic {
    PH_DELAY,
    PH_PERIOD
  } phase_t;

  logic [NUM_KEYS-1:0] r_sync1;
  logic [NUM_KEYS-1:0] r_sync2;
  logic [NUM_KEYS-1:0] r_stable;
  logic [NUM_KEYS-1:0] r_press;
  logic [NUM_KEYS-1:0] r_release;
  logic [NUM_KEYS-1:0] r_repeat;
  logic [CNT_W-1:0]    r_dcnt  [NUM_KEYS];
  logic [CNT_W-1:0]    r_rcnt  [NUM_KEYS];
  phase_t              r_phase [NUM_KEYS];

  logic [NUM_KEYS-1:0] w_raw;
  logic [NUM_KEYS-1:0] w_stable_nx;
  logic [NUM_KEYS-1:0] w_press_nx;
  logic [NUM_KEYS-1:0] w_release_nx;
  logic [NUM_KEYS-1:0] w_tick_nx;
  logic [CNT_W-1:0]    w_dcnt_nx  [NUM_KEYS];
  logic [CNT_W-1:0]    w_rcnt_nx  [NUM_KEYS];
  phase_t              w_phase_nx [NUM_KEYS];
  logic [CNT_W-1:0]    w_dinc;
  logic [CNT_W-1:0]    w_rinc;
  logic [CNT_W-1:0]    w_rlim;

  assign w_raw = ~r_sync2;

  always_comb begin
    w_stable_nx  = r_stable;
    w_press_nx   = '0;
    w_release_nx = '0;
    w_tick_nx    = '0;
    w_dinc       = '0;
    w_rinc       = '0;
    w_rlim       = '0;
    for (int i = 0; i < NUM_KEYS; i++) begin
      w_dcnt_nx[i]  = '0;
      w_rcnt_nx[i]  = '0;
      w_phase_nx[i] = r_phase[i];
      w_dinc = r_dcnt[i] + CNT_W'(1);
      if (w_raw[i] != r_stable[i]) begin
        if (w_dinc == DEBOUNCE_CYCLES) begin
          w_stable_nx[i]  = w_raw[i];
          w_press_nx[i]   = w_raw[i];
          w_release_nx[i] = ~w_raw[i];
        end else begin
          w_dcnt_nx[i] = w_dinc;
        end
      end
      w_rinc = r_rcnt[i] + CNT_W'(1);
      w_rlim = (r_phase[i] == PH_DELAY) ? REPEAT_DELAY
                                        : REPEAT_PERIOD;
      // release edge leaves the counter cleared and emits no tick
      if (REPEAT_MASK[i]) begin
        if (w_press_nx[i]) begin
          w_phase_nx[i] = PH_DELAY;
        end else if (r_stable[i] && !w_release_nx[i]) begin
          if (w_rinc == w_rlim) begin
            w_tick_nx[i]  = 1'b1;
            w_phase_nx[i] = PH_PERIOD;
          end else begin
            w_rcnt_nx[i] = w_rinc;
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1   <= '1;
      r_sync2   <= '1;
      r_stable  <= '0;
      r_press   <= '0;
      r_release <= '0;
      r_repeat  <= '0;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_dcnt[i]  <= '0;
        r_rcnt[i]  <= '0;
        r_phase[i] <= PH_DELAY;
      end
    end else begin
      r_sync1   <= kif.key_n_raw;
      r_sync2   <= r_sync1;
      r_stable  <= w_stable_nx;
      r_press   <= w_press_nx;
      r_release <= w_release_nx;
      r_repeat  <= w_press_nx | w_tick_nx;
      for (int i = 0; i < NUM_KEYS; i++) begin
        r_dcnt[i]  <= w_dcnt_nx[i];
        r_rcnt[i]  <= w_rcnt_nx[i];
        r_phase[i] <= w_phase_nx[i];
      end
    end
  end

  assign kif.key_level   = r_stable;
  assign kif.key_press   = r_press;
  assign kif.key_release = r_release;
  assign kif.key_repeat  = r_repeat;

endmodule
